// File: rtl/cga_vram_arbiter_pkg.sv
// rtl/cga_vram_arbiter_pkg.sv - shared ISA access FSM encoding and next-state helper
package cga_vram_arbiter_pkg;

  localparam int ISA_ACCESS_CYCLES = 3;

  // DONE is numbered so that its code equals the access length in cycles.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'(ISA_ACCESS_CYCLES);

  // A display fetch inside SETUP/ACCESS sends the access back to SETUP for a retry.
  function automatic logic [1:0] isa_next_state(input logic [1:0] st,
                                                input logic       start,
                                                input logic       disp_busy);
    case (st)
      ST_IDLE:   return start ? ST_SETUP : ST_IDLE;
      ST_SETUP:  return disp_busy ? ST_SETUP : ST_ACCESS;
      ST_ACCESS: return disp_busy ? ST_SETUP : ST_DONE;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cga_isa_req_latch.sv
// rtl/cga_isa_req_latch.sv - single-entry CPU request holder with IOCHRDY wait generation
module cga_isa_req_latch #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  input  logic              done_i,
  output logic              pending_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        wdata_o,
  output logic              wait_o
);

  logic              pending_q, pending_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              accept;

  // A request arriving while one is held (including its DONE cycle) is dropped.
  assign accept = req_i & ~pending_q;

  always_comb begin
    pending_d = pending_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (accept) begin
      pending_d = 1'b1;
      we_d      = we_i;
      addr_d    = addr_i;
      wdata_d   = wdata_i;
    end else if (done_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pending_o = pending_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign wait_o    = (pending_q & ~done_i) | accept;

endmodule

// File: rtl/cga_vram_arbiter.sv
// rtl/cga_vram_arbiter.sv - VRAM port owner: display fetch mux, byte latches, CPU access FSM
module cga_vram_arbiter
  import cga_vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vram_read,
  input  logic              vram_read_a0,
  input  logic              vram_read_char,
  input  logic              vram_read_att,
  input  logic              isa_op_enable,
  input  logic [ADDR_W-2:0] disp_addr,
  input  logic              isa_req,
  input  logic              isa_we,
  input  logic [ADDR_W-1:0] isa_addr,
  input  logic [7:0]        isa_wdata,
  output logic [7:0]        isa_rdata,
  output logic              isa_ack,
  output logic              isa_wait,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din,
  output logic [7:0]        vram_char,
  output logic [7:0]        vram_att
);

  logic [1:0]        state_q, state_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        char_q, char_d;
  logic [7:0]        att_q, att_d;
  logic              pending, req_we, done, start, in_access;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;

  assign done      = (state_q == ST_DONE);
  assign in_access = (state_q == ST_SETUP) | (state_q == ST_ACCESS);
  // A fresh request may launch in its own cycle, before it is registered.
  assign start     = (state_q == ST_IDLE) & (pending | isa_req) & isa_op_enable & ~vram_read;

  cga_isa_req_latch #(.ADDR_W(ADDR_W)) u_req (
    .clk_i     (clk),
    .rst_i     (reset),
    .req_i     (isa_req),
    .we_i      (isa_we),
    .addr_i    (isa_addr),
    .wdata_i   (isa_wdata),
    .done_i    (done),
    .pending_o (pending),
    .we_o      (req_we),
    .addr_o    (req_addr),
    .wdata_o   (req_wdata),
    .wait_o    (isa_wait)
  );

  always_comb begin
    state_d = isa_next_state(state_q, start, vram_read);
    rdata_d = rdata_q;
    char_d  = vram_read_char ? ram_din : char_q;
    att_d   = vram_read_att  ? ram_din : att_q;
    if (done && !req_we) rdata_d = ram_din;
  end

  // Display always wins the port; write enable never leaks into a fetch cycle.
  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_we   = 1'b0;
    if (vram_read) begin
      ram_a = {disp_addr, vram_read_a0};
    end else if (in_access) begin
      ram_a    = req_addr;
      ram_dout = req_wdata;
      ram_we   = (state_q == ST_ACCESS) & req_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      char_q  <= '0;
      att_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      char_q  <= char_d;
      att_q   <= att_d;
    end
  end

  assign isa_ack   = done;
  assign isa_rdata = rdata_d;
  assign vram_char = char_q;
  assign vram_att  = att_q;

endmodule
